// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo-N up/down counter with wrap, saturate and one-shot end-of-range modes
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   en_i         count enable, one step per clock
//   up_dn_i      1 = count up, 0 = count down
//   clr_i        synchronous clear to 0 (highest priority)
//   load_i       synchronous load of load_val_i, clamped to N-1
//   load_val_i   value to load
//   mode_i       00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   data_out_o   registered count, always within 0..N-1
//   tc_o         combinational terminal count for the current direction
//   carry_o      registered one-cycle pulse following a wrap
//   done_o       registered; one-shot has reached its terminal value
module updown_mod_counter #(
    parameter int N      = 9,
    parameter int DWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              up_dn_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DWIDTH-1:0] load_val_i,
    input  logic [1:0]        mode_i,
    output logic [DWIDTH-1:0] data_out_o,
    output logic              tc_o,
    output logic              carry_o,
    output logic              done_o
);
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;
    localparam logic [DWIDTH-1:0] MAX = DWIDTH'(N - 1);
    localparam logic [DWIDTH-1:0] ONE = DWIDTH'(1);
    logic [DWIDTH-1:0] data_q, data_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;
    logic [DWIDTH-1:0] term, step, wrapped;
    mode_e             mode;
    logic              oneshot, wrap_mode;
    assign mode       = mode_e'(mode_i);
    assign oneshot    = mode == MODE_ONESHOT;
    assign wrap_mode  = mode == MODE_WRAP || mode == MODE_RSVD;
    assign term       = up_dn_i ? MAX : '0;
    assign wrapped    = up_dn_i ? '0 : MAX;
    assign step       = up_dn_i ? data_q + ONE : data_q - ONE;
    assign tc_o       = data_q == term;
    assign data_out_o = data_q;
    assign carry_o    = carry_q;
    assign done_o     = done_q;
    always_comb begin
        data_d  = data_q;
        carry_d = 1'b0;
        done_d  = done_q;
        if (clr_i) begin
            data_d = '0;
            done_d = 1'b0;
        end else if (load_i) begin
            data_d = load_val_i > MAX ? MAX : load_val_i;
            done_d = 1'b0;
        end else if (en_i && !done_q) begin
            if (!tc_o) begin
                data_d = step;
                // one-shot flags done on the very edge that lands on the terminal value
                done_d = oneshot && step == term;
            end else if (wrap_mode) begin
                data_d  = wrapped;
                carry_d = 1'b1;
            end else begin
                done_d = oneshot;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: table-driven and scoreboard checks of updown_mod_counter (N=9 and N=16)
module tb_updown_mod_counter;
    localparam int N9 = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [1:0] mode = '0;
    logic [3:0] d9, d16;
    logic       tc9, c9, dn9, tc16, c16, dn16;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       en, up, clr, load;
        logic [3:0] lv;
        logic [1:0] mode;
        int         ed, etc, ec, edn;
    } vec_t;

    typedef struct {
        int d, tc, c, dn;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int m_cnt = 0, m_carry = 0, m_done = 0;

    updown_mod_counter #(.N(9), .DWIDTH(4)) dut9 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .clr_i(clr),
        .load_i(load), .load_val_i(load_val), .mode_i(mode),
        .data_out_o(d9), .tc_o(tc9), .carry_o(c9), .done_o(dn9)
    );

    updown_mod_counter #(.N(16), .DWIDTH(4)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .up_dn_i(up_dn), .clr_i(clr),
        .load_i(load), .load_val_i(load_val), .mode_i(mode),
        .data_out_o(d16), .tc_o(tc16), .carry_o(c16), .done_o(dn16)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, u, c, l, input int lv, md, ed, etc, ec, edn);
        vec_t v;
        v.en = e; v.up = u; v.clr = c; v.load = l;
        v.lv = 4'(lv); v.mode = 2'(md);
        v.ed = ed; v.etc = etc; v.ec = ec; v.edn = edn;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int t;
        t = up_dn ? N9 - 1 : 0;
        if (clr) begin
            m_cnt = 0; m_carry = 0; m_done = 0;
        end else if (load) begin
            m_cnt = (int'(load_val) >= N9) ? N9 - 1 : int'(load_val);
            m_carry = 0; m_done = 0;
        end else if (!en || m_done != 0) begin
            m_carry = 0;
        end else if (m_cnt != t) begin
            m_cnt = up_dn ? m_cnt + 1 : m_cnt - 1;
            m_carry = 0;
            if (mode == 2'b10 && m_cnt == t) m_done = 1;
        end else if (mode == 2'b01) begin
            m_carry = 0;
        end else if (mode == 2'b10) begin
            m_carry = 0; m_done = 1;
        end else begin
            m_cnt = up_dn ? 0 : N9 - 1;
            m_carry = 1;
        end
    endtask

    task automatic cyc(input logic e, u, c, l, input logic [3:0] lv, input logic [1:0] md);
        exp_t x, got;
        en = e; up_dn = u; clr = c; load = l; load_val = lv; mode = md;
        model_step();
        x.d = m_cnt; x.c = m_carry; x.dn = m_done;
        x.tc = (m_cnt == (u ? N9 - 1 : 0)) ? 1 : 0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_data", int'(d9), got.d);
        chk("sb_tc", int'(tc9), got.tc);
        chk("sb_carry", int'(c9), got.c);
        chk("sb_done", int'(dn9), got.dn);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; clr = 1'b0; load = 1'b0; up_dn = 1'b1; mode = 2'b00;
        m_cnt = 0; m_carry = 0; m_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, i, i == 8, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 6, 1, 6, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 7, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 1, 8, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 5, 2, 5, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2, 6, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 2, 7, 0, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 2, 8, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 8, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 3, 2, 3, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 15, 0, 8, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 9, 0, 8, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 4, 0, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8, 0, 8, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 8, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 8, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0, 1, 0, 1));

        do_reset();
        chk("rst_data", int'(d9), 0);
        chk("rst_tc", int'(tc9), 0);
        chk("rst_carry", int'(c9), 0);
        chk("rst_done", int'(dn9), 0);

        foreach (vecs[k]) begin
            cyc(vecs[k].en, vecs[k].up, vecs[k].clr, vecs[k].load, vecs[k].lv, vecs[k].mode);
            chk($sformatf("vec%0d_data", k), int'(d9), vecs[k].ed);
            chk($sformatf("vec%0d_tc", k), int'(tc9), vecs[k].etc);
            chk($sformatf("vec%0d_carry", k), int'(c9), vecs[k].ec);
            chk($sformatf("vec%0d_done", k), int'(dn9), vecs[k].edn);
        end

        cyc(0, 1, 0, 1, 4'd6, 2'b00);
        cyc(1, 1, 0, 0, 4'd0, 2'b00);
        chk("pre_arst_data", int'(d9), 7);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", int'(d9), 0);
        chk("arst_carry", int'(c9), 0);
        chk("arst_done", int'(dn9), 0);
        do_reset();

        cyc(0, 1, 0, 1, 4'd8, 2'b00);
        cyc(1, 1, 0, 0, 4'd0, 2'b00);
        chk("pre_arst_carry", int'(c9), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_carry_kill", int'(c9), 0);
        chk("arst_data2", int'(d9), 0);
        do_reset();

        cyc(0, 1, 0, 1, 4'd5, 2'b10);
        repeat (3) cyc(1, 1, 0, 0, 4'd0, 2'b10);
        chk("pre_arst_done", int'(dn9), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_done_kill", int'(dn9), 0);
        do_reset();

        chk("n16_rst_data", int'(d16), 0);
        en = 1'b1; up_dn = 1'b1; mode = 2'b00;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n16_data%0d", i), int'(d16), (i + 1) % 16);
            chk($sformatf("n16_tc%0d", i), int'(tc16), ((i + 1) % 16 == 15) ? 1 : 0);
            chk($sformatf("n16_carry%0d", i), int'(c16), (i == 15) ? 1 : 0);
        end
        chk("n16_done", int'(dn16), 0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
